// File: rtl/kd_sched_pkg.sv
// Shared state encoding and default widths for the KD-tree scheduler.
package kd_sched_pkg;

  localparam int STORAGE_WIDTH_DEF = 22;
  localparam int PATCH_WIDTH_DEF   = 55;
  localparam int ADDRESS_WIDTH_DEF = 8;
  localparam int QUERY_WIDTH       = 16;
  localparam int MAX_INFLIGHT_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_QUERY  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/kd_sched_result_fifo.sv
// Small synchronous FIFO holding tree leaf results until downstream accepts them.
// Head is visible combinationally so a result pushed at one edge is presented the next cycle.
module kd_sched_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW:0]      wr_ptr_reg;
  logic [PW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                   (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_reg[rd_ptr_reg[PW-1:0]];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (do_push && (wr_ptr_reg[PW-1:0] == PW'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/kd_tree_sched.sv
// Sequences node-word loading and credit-limited query streaming for the KD-tree engine.
// Optional KD_SCHED_CHECKSUM_EN adds a 16-bit running sum of loaded words.
module kd_tree_sched
  import kd_sched_pkg::*;
#(
  parameter int STORAGE_WIDTH = STORAGE_WIDTH_DEF,
  parameter int PATCH_WIDTH   = PATCH_WIDTH_DEF,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int MAX_INFLIGHT  = MAX_INFLIGHT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH:0]   load_words,
  input  logic [QUERY_WIDTH-1:0]   num_queries,
  input  logic                     agg_valid,
  input  logic [STORAGE_WIDTH-1:0] agg_data,
  output logic                     agg_ready,
  output logic                     node_wen,
  output logic [ADDRESS_WIDTH-1:0] node_waddr,
  output logic [STORAGE_WIDTH-1:0] node_wdata,
  input  logic                     patch_valid,
  input  logic [PATCH_WIDTH-1:0]   patch_data,
  output logic                     patch_ready,
  output logic                     fsm_enable,
  output logic                     tree_patch_valid,
  output logic [PATCH_WIDTH-1:0]   tree_patch,
  input  logic                     leaf_valid,
  input  logic [ADDRESS_WIDTH-1:0] leaf_index,
  output logic                     res_valid,
  output logic [ADDRESS_WIDTH-1:0] res_index,
  output logic [QUERY_WIDTH-1:0]   res_id,
  input  logic                     res_ready,
  output logic                     busy,
  output logic                     done
`ifdef KD_SCHED_CHECKSUM_EN
  ,
  output logic [15:0]              load_checksum
`endif
);

  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
  localparam logic [CW-1:0] CREDITS_INIT = CW'(MAX_INFLIGHT);

  state_t                   state_reg, state_next;
  logic [ADDRESS_WIDTH:0]   load_words_reg;
  logic [ADDRESS_WIDTH:0]   wcnt_reg;
  logic [QUERY_WIDTH-1:0]   num_queries_reg;
  logic [QUERY_WIDTH-1:0]   issued_reg;
  logic [QUERY_WIDTH-1:0]   returned_reg;
  logic [CW-1:0]            credits_reg;
  logic                     node_wen_reg;
  logic [ADDRESS_WIDTH-1:0] node_waddr_reg;
  logic [STORAGE_WIDTH-1:0] node_wdata_reg;
  logic                     tree_patch_valid_reg;
  logic [PATCH_WIDTH-1:0]   tree_patch_reg;
  logic                     fsm_enable_reg;
  logic                     busy_reg;
  logic                     done_reg;

  logic agg_fire, patch_fire, last_word, take_start;
  logic fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign take_start  = (state_reg == ST_IDLE) && start;
  assign agg_ready   = (state_reg == ST_LOAD);
  assign patch_ready = (state_reg == ST_QUERY) && (credits_reg != '0) &&
                       (issued_reg < num_queries_reg);
  assign agg_fire    = agg_valid && agg_ready;
  assign patch_fire  = patch_valid && patch_ready;
  assign last_word   = ((wcnt_reg + (ADDRESS_WIDTH + 1)'(1)) == load_words_reg);

  // Results arriving outside QUERY or into a full FIFO are discarded.
  assign fifo_push = leaf_valid && (state_reg == ST_QUERY) && !fifo_full;
  assign res_valid = !fifo_empty;
  assign fifo_pop  = res_valid && res_ready;
  assign res_id    = returned_reg;

  assign node_wen         = node_wen_reg;
  assign node_waddr       = node_waddr_reg;
  assign node_wdata       = node_wdata_reg;
  assign tree_patch_valid = tree_patch_valid_reg;
  assign tree_patch       = tree_patch_reg;
  assign fsm_enable       = fsm_enable_reg;
  assign busy             = busy_reg;
  assign done             = done_reg;

  kd_sched_result_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (ADDRESS_WIDTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (leaf_index),
    .pop       (fifo_pop),
    .head      (res_index),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (load_words != '0)       state_next = ST_LOAD;
          else if (num_queries != '0) state_next = ST_QUERY;
          else                        state_next = ST_FINISH;
        end
      end
      ST_LOAD: begin
        if (agg_fire && last_word)
          state_next = (num_queries_reg == '0) ? ST_FINISH : ST_QUERY;
      end
      ST_QUERY: begin
        if (returned_reg == num_queries_reg) state_next = ST_FINISH;
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg            <= ST_IDLE;
      load_words_reg       <= '0;
      num_queries_reg      <= '0;
      wcnt_reg             <= '0;
      issued_reg           <= '0;
      returned_reg         <= '0;
      credits_reg          <= CREDITS_INIT;
      node_wen_reg         <= 1'b0;
      node_waddr_reg       <= '0;
      node_wdata_reg       <= '0;
      tree_patch_valid_reg <= 1'b0;
      tree_patch_reg       <= '0;
      fsm_enable_reg       <= 1'b0;
      busy_reg             <= 1'b0;
      done_reg             <= 1'b0;
    end else begin
      state_reg            <= state_next;
      node_wen_reg         <= agg_fire;
      tree_patch_valid_reg <= patch_fire;
      // Status flags follow the next state so they line up with the state register.
      fsm_enable_reg       <= (state_next == ST_QUERY);
      busy_reg             <= (state_next != ST_IDLE);
      done_reg             <= (state_next == ST_FINISH);
      if (agg_fire) begin
        node_waddr_reg <= wcnt_reg[ADDRESS_WIDTH-1:0];
        node_wdata_reg <= agg_data;
      end
      if (patch_fire) tree_patch_reg <= patch_data;
      if (take_start) begin
        load_words_reg  <= load_words;
        num_queries_reg <= num_queries;
        wcnt_reg        <= '0;
        issued_reg      <= '0;
        returned_reg    <= '0;
        credits_reg     <= CREDITS_INIT;
      end else begin
        if (agg_fire)   wcnt_reg     <= wcnt_reg + (ADDRESS_WIDTH + 1)'(1);
        if (patch_fire) issued_reg   <= issued_reg + 1'b1;
        if (fifo_pop)   returned_reg <= returned_reg + 1'b1;
        credits_reg <= credits_reg + CW'(fifo_pop) - CW'(patch_fire);
      end
    end
  end

  // A well-behaved tree never returns more results than there are credits.
  always @(posedge clk) begin
    if (!rst && leaf_valid && (state_reg == ST_QUERY)) assert (!fifo_full);
  end

`ifdef KD_SCHED_CHECKSUM_EN
  logic [15:0] checksum_reg;
  logic [15:0] agg_low;

  always_comb begin
    agg_low = '0;
    for (int i = 0; i < 16 && i < STORAGE_WIDTH; i++) agg_low[i] = agg_data[i];
  end

  always_ff @(posedge clk) begin
    if (rst)            checksum_reg <= '0;
    else if (take_start) checksum_reg <= '0;
    else if (agg_fire)  checksum_reg <= checksum_reg + agg_low;
  end

  assign load_checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_kd_tree_sched.sv
// Scoreboard bench for kd_tree_sched: a tree model returns patch[7:0] as the leaf index.
`timescale 1ns/1ps
module tb_kd_tree_sched;

  localparam int SW = 22;
  localparam int PW = 55;
  localparam int AW = 8;
  localparam int TREE_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   load_words = '0;
  logic [15:0]   num_queries = '0;
  logic          agg_valid = 1'b0;
  logic [SW-1:0] agg_data = '0;
  logic          agg_ready;
  logic          node_wen;
  logic [AW-1:0] node_waddr;
  logic [SW-1:0] node_wdata;
  logic          patch_valid = 1'b0;
  logic [PW-1:0] patch_data = '0;
  logic          patch_ready;
  logic          fsm_enable;
  logic          tree_patch_valid;
  logic [PW-1:0] tree_patch;
  logic          leaf_valid = 1'b0;
  logic [AW-1:0] leaf_index = '0;
  logic          res_valid;
  logic [AW-1:0] res_index;
  logic [15:0]   res_id;
  logic          res_ready = 1'b0;
  logic          busy;
  logic          done;
`ifdef KD_SCHED_CHECKSUM_EN
  logic [15:0]   load_checksum;
`endif

  kd_tree_sched dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .load_words       (load_words),
    .num_queries      (num_queries),
    .agg_valid        (agg_valid),
    .agg_data         (agg_data),
    .agg_ready        (agg_ready),
    .node_wen         (node_wen),
    .node_waddr       (node_waddr),
    .node_wdata       (node_wdata),
    .patch_valid      (patch_valid),
    .patch_data       (patch_data),
    .patch_ready      (patch_ready),
    .fsm_enable       (fsm_enable),
    .tree_patch_valid (tree_patch_valid),
    .tree_patch       (tree_patch),
    .leaf_valid       (leaf_valid),
    .leaf_index       (leaf_index),
    .res_valid        (res_valid),
    .res_index        (res_index),
    .res_id           (res_id),
    .res_ready        (res_ready),
    .busy             (busy),
    .done             (done)
`ifdef KD_SCHED_CHECKSUM_EN
    ,
    .load_checksum    (load_checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [SW-1:0] data; int due; } nw_t;
  typedef struct { logic [PW-1:0] patch; int due; } tp_t;
  typedef struct { logic [AW-1:0] idx; logic [15:0] id; } res_t;
  typedef struct { logic [AW-1:0] idx; int due; } leaf_t;

  nw_t   exp_nw[$];
  tp_t   exp_tp[$];
  res_t  exp_res[$];
  leaf_t leaf_pipe[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nw_cnt = 0;
  int tp_cnt = 0;
  int done_cnt = 0;
  int job_waddr = 0;
  int job_issue = 0;
  bit rand_on = 1'b0;
  logic [15:0] exp_sum = '0;

  nw_t   m_nw;
  tp_t   m_tp;
  res_t  m_res;
  leaf_t m_leaf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout/unexpected want event", name);
  endtask

  // Monitors: node writes, tree issues (plus tree model), results, done pulses.
  always @(negedge clk) begin
    if (node_wen === 1'b1) begin
      nw_cnt++;
      if (exp_nw.size() == 0) fail_now("unexpected_node_write");
      else begin
        m_nw = exp_nw.pop_front();
        chk("node_waddr", 64'(node_waddr), 64'(m_nw.addr));
        chk("node_wdata", 64'(node_wdata), 64'(m_nw.data));
        chk("node_write_cycle", 64'(cyc), 64'(m_nw.due));
        $display("node write addr=%0d data=%0h", node_waddr, node_wdata);
      end
    end
    if (tree_patch_valid === 1'b1) begin
      tp_cnt++;
      if (exp_tp.size() == 0) fail_now("unexpected_tree_issue");
      else begin
        m_tp = exp_tp.pop_front();
        chk("tree_patch", 64'(tree_patch), 64'(m_tp.patch));
        chk("tree_issue_cycle", 64'(cyc), 64'(m_tp.due));
        $display("tree issue patch=%0h", tree_patch);
      end
      m_leaf.idx = tree_patch[AW-1:0];
      m_leaf.due = cyc + TREE_LAT;
      leaf_pipe.push_back(m_leaf);
    end
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_res.size() == 0) fail_now("unexpected_result");
      else begin
        m_res = exp_res.pop_front();
        chk("res_index", 64'(res_index), 64'(m_res.idx));
        chk("res_id", 64'(res_id), 64'(m_res.id));
        $display("result id=%0d index=%0d", res_id, res_index);
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      leaf_valid = 1'b0;
      if (leaf_pipe.size() != 0 && leaf_pipe[0].due <= cyc) begin
        m_leaf = leaf_pipe.pop_front();
        leaf_valid = 1'b1;
        leaf_index = m_leaf.idx;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_on) res_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic start_job(input int l, input int q);
    load_words  = (AW + 1)'(l);
    num_queries = 16'(q);
    job_waddr   = 0;
    job_issue   = 0;
    exp_sum     = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_agg(input logic [SW-1:0] d, input int gap);
    bit got = 1'b0;
    int t = 0;
    repeat (gap) begin @(posedge clk); #1; end
    agg_valid = 1'b1;
    agg_data  = d;
    while (!got && t < 400) begin
      @(negedge clk);
      if (agg_ready) got = 1'b1;
      else begin @(posedge clk); #1; t++; end
    end
    if (got) begin
      m_nw.addr = AW'(job_waddr);
      m_nw.data = d;
      m_nw.due  = cyc + 1;
      exp_nw.push_back(m_nw);
      job_waddr++;
      exp_sum = exp_sum + d[15:0];
      @(posedge clk); #1;
    end else fail_now("agg_ready_timeout");
    agg_valid = 1'b0;
  endtask

  task automatic note_patch(input logic [PW-1:0] d);
    tp_t  tp;
    res_t rs;
    tp.patch = d;
    tp.due   = cyc + 1;
    exp_tp.push_back(tp);
    rs.idx = d[AW-1:0];
    rs.id  = 16'(job_issue);
    exp_res.push_back(rs);
    job_issue++;
  endtask

  task automatic send_patch(input logic [PW-1:0] d, input int gap);
    bit got = 1'b0;
    int t = 0;
    repeat (gap) begin @(posedge clk); #1; end
    patch_valid = 1'b1;
    patch_data  = d;
    while (!got && t < 400) begin
      @(negedge clk);
      if (patch_ready) got = 1'b1;
      else begin @(posedge clk); #1; t++; end
    end
    if (got) begin
      note_patch(d);
      @(posedge clk); #1;
    end else fail_now("patch_ready_timeout");
    patch_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen = 1'b0;
    for (int t = 0; t < limit && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) fail_now("done_timeout");
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_agg_ready"}, 64'(agg_ready), 0);
    chk({tag, "_node_wen"}, 64'(node_wen), 0);
    chk({tag, "_node_waddr"}, 64'(node_waddr), 0);
    chk({tag, "_node_wdata"}, 64'(node_wdata), 0);
    chk({tag, "_patch_ready"}, 64'(patch_ready), 0);
    chk({tag, "_fsm_enable"}, 64'(fsm_enable), 0);
    chk({tag, "_tree_patch_valid"}, 64'(tree_patch_valid), 0);
    chk({tag, "_tree_patch"}, 64'(tree_patch), 0);
    chk({tag, "_res_valid"}, 64'(res_valid), 0);
    chk({tag, "_res_id"}, 64'(res_id), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nw0, tp0, d0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Load only: 5, 9, 12 to addresses 0..2
    nw0 = nw_cnt; d0 = done_cnt;
    start_job(3, 0);
    chk("load_agg_ready", 64'(agg_ready), 1);
    chk("load_busy", 64'(busy), 1);
    chk("load_fsm_enable", 64'(fsm_enable), 0);
    send_agg(22'd5, 0);
    send_agg(22'd9, 0);
    send_agg(22'd12, 0);
    wait_done(20);
    chk("load_only_writes", 64'(nw_cnt - nw0), 3);
    chk("load_only_done", 64'(done_cnt - d0), 1);
    chk("load_only_idle", 64'(busy), 0);
`ifdef KD_SCHED_CHECKSUM_EN
    chk("load_only_checksum", 64'(load_checksum), 26);
`endif

    // Zero load: leaves 7 and 3
    nw0 = nw_cnt; tp0 = tp_cnt; d0 = done_cnt;
    res_ready = 1'b1;
    start_job(0, 2);
    chk("zero_load_fsm_enable", 64'(fsm_enable), 1);
    chk("zero_load_agg_ready", 64'(agg_ready), 0);
    send_patch(55'h1234_5607, 0);
    send_patch(55'h0abc_de03, 0);
    wait_done(50);
    chk("zero_load_no_writes", 64'(nw_cnt - nw0), 0);
    chk("zero_load_issues", 64'(tp_cnt - tp0), 2);
    chk("zero_load_results_left", 64'(exp_res.size()), 0);
    chk("zero_load_done", 64'(done_cnt - d0), 1);

    // Backpressure: 10 offered, 4 credits
    tp0 = tp_cnt; d0 = done_cnt;
    res_ready = 1'b0;
    start_job(0, 10);
    fork
      begin
        for (int i = 0; i < 10; i++) send_patch(PW'(256 + i * 17), 0);
      end
    join_none
    repeat (30) begin @(posedge clk); #1; end
    chk("bp_issued", 64'(tp_cnt - tp0), 4);
    chk("bp_patch_ready", 64'(patch_ready), 0);
    chk("bp_res_valid", 64'(res_valid), 1);
    res_ready = 1'b1;
    wait_done(500);
    chk("bp_total_issued", 64'(tp_cnt - tp0), 10);
    chk("bp_results_left", 64'(exp_res.size()), 0);
    chk("bp_done", 64'(done_cnt - d0), 1);

    // Simultaneous issue and pop at credits 1
    d0 = done_cnt;
    res_ready = 1'b0;
    start_job(0, 5);
    send_patch(55'h11, 0);
    send_patch(55'h22, 0);
    send_patch(55'h33, 0);
    repeat (8) begin @(posedge clk); #1; end
    patch_valid = 1'b1;
    patch_data  = 55'h44;
    res_ready   = 1'b1;
    @(negedge clk);
    chk("sim_patch_ready", 64'(patch_ready), 1);
    chk("sim_res_valid", 64'(res_valid), 1);
    if (patch_ready) note_patch(55'h44);
    @(posedge clk); #1;
    res_ready  = 1'b0;
    patch_data = 55'h55;
    @(negedge clk);
    chk("sim_credit_kept", 64'(patch_ready), 1);
    if (patch_ready) note_patch(55'h55);
    @(posedge clk); #1;
    patch_valid = 1'b0;
    res_ready = 1'b1;
    wait_done(100);
    chk("sim_results_left", 64'(exp_res.size()), 0);
    chk("sim_done", 64'(done_cnt - d0), 1);

    // Random gaps: 128 words, 20 queries
    nw0 = nw_cnt; tp0 = tp_cnt; d0 = done_cnt;
    start_job(128, 20);
    for (int i = 0; i < 128; i++) send_agg(SW'(i * 4099 + 7), $urandom_range(0, 2));
    rand_on = 1'b1;
    for (int i = 0; i < 20; i++) send_patch(PW'(1000 + i * 37), $urandom_range(0, 3));
    rand_on = 1'b0;
    res_ready = 1'b1;
    wait_done(200);
    chk("rand_writes", 64'(nw_cnt - nw0), 128);
    chk("rand_writes_left", 64'(exp_nw.size()), 0);
    chk("rand_issues", 64'(tp_cnt - tp0), 20);
    chk("rand_results_left", 64'(exp_res.size()), 0);
    chk("rand_done", 64'(done_cnt - d0), 1);
`ifdef KD_SCHED_CHECKSUM_EN
    chk("rand_checksum", 64'(load_checksum), 64'(exp_sum));
`endif

    // Reset mid-LOAD after 2 words, then a fresh job
    start_job(5, 1);
    send_agg(22'd11, 0);
    send_agg(22'd22, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midload");
    chk("midload_writes_left", 64'(exp_nw.size()), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    nw0 = nw_cnt; d0 = done_cnt;
    start_job(2, 1);
    send_agg(22'd33, 0);
    send_agg(22'd44, 0);
    send_patch(55'h2a, 0);
    wait_done(50);
    chk("restart_writes", 64'(nw_cnt - nw0), 2);
    chk("restart_results_left", 64'(exp_res.size()), 0);
    chk("restart_done", 64'(done_cnt - d0), 1);
`ifdef KD_SCHED_CHECKSUM_EN
    chk("restart_checksum", 64'(load_checksum), 77);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
